// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - sequencer feeding one 3x3 convolution unit and collecting its results
module conv_seq_ctrl #(
   parameter int IMG_W   = 14,
   parameter int K       = 3,
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 36,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              ifm_rd_en,
   output logic [7:0]        ifm_rd_addr,
   input  logic [DATA_W-1:0] ifm_rd_data,
   output logic              wgt_rd_en,
   output logic [3:0]        wgt_rd_addr,
   input  logic [DATA_W-1:0] wgt_rd_data,
   output logic              conv_in_valid,
   output logic [DATA_W-1:0] conv_ifm,
   output logic [DATA_W-1:0] conv_weight,
   input  logic              conv_out_valid,
   input  logic [ACC_W-1:0]  conv_out,
   output logic              ofm_wr_en,
   output logic [7:0]        ofm_wr_addr,
   output logic [ACC_W-1:0]  ofm_wr_data
);

   localparam int NPIX = IMG_W * IMG_W;
   localparam int NW   = K * K;
   localparam int NOUT = (IMG_W - K + 1) * (IMG_W - K + 1);
   localparam int RW   = $clog2(NPIX + 1);
   localparam int OW   = $clog2(NOUT + 1);
   localparam int TW   = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [RW-1:0] rd_cnt;
   logic [OW-1:0] out_cnt;
   logic [TW-1:0] idle_cnt;
   logic          in_vld_q, wgt_vld_q;
   logic          capture, accept, spurious, start_ok, timeout_hit;

   always_comb begin
      state_nxt   = state;
      start_ok    = 1'b0;
      timeout_hit = 1'b0;
      capture     = (state == S_FEED) || (state == S_FLUSH) || (state == S_DRAIN);
      // A result arriving outside capture, or beyond the last OFM slot, is dropped and flagged
      accept      = capture && conv_out_valid && (out_cnt != OW'(NOUT));
      spurious    = conv_out_valid && !accept;
      case (state)
         S_IDLE: begin
            if (start) begin
               start_ok  = 1'b1;
               state_nxt = S_FEED;
            end
         end
         S_FEED: begin
            if (rd_cnt == RW'(NPIX - 1)) state_nxt = S_FLUSH;
         end
         S_FLUSH: state_nxt = S_DRAIN;
         S_DRAIN: begin
            if ((out_cnt == OW'(NOUT)) || (accept && (out_cnt == OW'(NOUT - 1)))) begin
               state_nxt = S_DONE;
            end else if (!conv_out_valid && (idle_cnt == TW'(TIMEOUT - 1))) begin
               timeout_hit = 1'b1;
               state_nxt   = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy        = capture;
   assign done        = (state == S_DONE);
   assign ifm_rd_en   = (state == S_FEED);
   assign wgt_rd_en   = (state == S_FEED) && (rd_cnt < RW'(NW));
   assign ifm_rd_addr = ifm_rd_en ? 8'(rd_cnt) : 8'd0;
   assign wgt_rd_addr = wgt_rd_en ? 4'(rd_cnt) : 4'd0;

   assign conv_in_valid = in_vld_q;
   assign conv_ifm      = in_vld_q  ? ifm_rd_data : '0;
   assign conv_weight   = wgt_vld_q ? wgt_rd_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rd_cnt      <= '0;
         out_cnt     <= '0;
         idle_cnt    <= '0;
         in_vld_q    <= 1'b0;
         wgt_vld_q   <= 1'b0;
         err         <= 1'b0;
         ofm_wr_en   <= 1'b0;
         ofm_wr_addr <= '0;
         ofm_wr_data <= '0;
      end else begin
         state     <= state_nxt;
         in_vld_q  <= ifm_rd_en;
         wgt_vld_q <= wgt_rd_en;
         if (start_ok) begin
            rd_cnt  <= '0;
            out_cnt <= '0;
         end else begin
            if (ifm_rd_en) rd_cnt  <= rd_cnt + RW'(1);
            if (accept)    out_cnt <= out_cnt + OW'(1);
         end
         if ((state != S_DRAIN) || conv_out_valid) idle_cnt <= '0;
         else                                      idle_cnt <= idle_cnt + TW'(1);
         ofm_wr_en   <= accept;
         ofm_wr_addr <= accept ? 8'(out_cnt) : 8'd0;
         ofm_wr_data <= accept ? conv_out : '0;
         if (spurious || timeout_hit) err <= 1'b1;
         else if (start_ok)           err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - directed self-checking bench for conv_seq_ctrl
module tb_conv_seq_ctrl;

   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic        busy, done, err;
   logic        ifm_rd_en, wgt_rd_en;
   logic [7:0]  ifm_rd_addr;
   logic [3:0]  wgt_rd_addr;
   logic [15:0] ifm_rd_data, wgt_rd_data;
   logic        conv_in_valid;
   logic [15:0] conv_ifm, conv_weight;
   logic        conv_out_valid;
   logic [35:0] conv_out;
   logic        ofm_wr_en;
   logic [7:0]  ofm_wr_addr;
   logic [35:0] ofm_wr_data;

   conv_seq_ctrl #(.IMG_W(14), .K(3), .DATA_W(16), .ACC_W(36), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
      .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr), .ifm_rd_data(ifm_rd_data),
      .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
      .conv_in_valid(conv_in_valid), .conv_ifm(conv_ifm), .conv_weight(conv_weight),
      .conv_out_valid(conv_out_valid), .conv_out(conv_out),
      .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr), .ofm_wr_data(ofm_wr_data)
   );

   always #5 clk = ~clk;

   // Buffers: IFM[i] = i, weights 1..9, one-cycle read latency
   always @(posedge clk) begin
      if (ifm_rd_en) ifm_rd_data <= 16'(ifm_rd_addr);
      if (wgt_rd_en) wgt_rd_data <= 16'(wgt_rd_addr) + 16'd1;
   end

   function automatic logic [35:0] res_val(input int i);
      return 36'hA_5000_0000 + 36'(i) * 36'h3_0007;
   endfunction

   int checks = 0, failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int val, input int lo, input int hi);
      checks++;
      if (val < lo || val > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
      end
   endtask

   // Monitor samples 1 time unit after each rising edge
   int   tick = 0, fbeat = 0, fwr = 0, wr_total = 0, gap_cnt = 0, feed_bad = 0, ofm_bad = 0;
   int   done_cnt = 0, done_tick = 0, last_wr_tick = 0, rise_tick = 0, rise_cnt = 0;
   int   first_beat_tick = 0, rise_gap = 0;
   logic busy_q = 1'b0;

   always @(posedge clk) begin
      #1;
      tick++;
      if (busy && !busy_q) begin
         fbeat     = 0;
         fwr       = 0;
         rise_gap  = tick - done_tick;
         rise_tick = tick;
         rise_cnt++;
      end
      busy_q = busy;
      if (conv_in_valid) begin
         if (fbeat == 0) first_beat_tick = tick;
         if (conv_ifm !== 16'(fbeat) || conv_weight !== ((fbeat < 9) ? 16'(fbeat + 1) : 16'd0))
            feed_bad++;
         fbeat++;
      end else begin
         if (conv_ifm !== 16'd0 || conv_weight !== 16'd0) feed_bad++;
         if (busy && fbeat > 0 && fbeat < 196) gap_cnt++;
      end
      if (ofm_wr_en) begin
         if (ofm_wr_addr !== 8'(fwr) || ofm_wr_data !== res_val(fwr)) ofm_bad++;
         fwr++;
         wr_total++;
         last_wr_tick = tick;
      end
      if (done) begin
         done_cnt++;
         done_tick = tick;
      end
   end

   typedef struct {
      string name;
      int    n_res;
      int    trig_beat;
      int    trig_dly;
      int    n_gaps;
      int    exp_wr;
      int    exp_err;
      int    lag_min;
      int    lag_max;
   } scen_t;

   scen_t tbl[4];

   task automatic run_frame(input scen_t s);
      int d0, g0, f0, o0, w0, sent, dly, gaps_left;
      bit gap;
      d0 = done_cnt; g0 = gap_cnt; f0 = feed_bad; o0 = ofm_bad; w0 = wr_total;
      sent = 0; dly = -1; gaps_left = s.n_gaps; gap = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         conv_out_valid = 1'b0;
         conv_out       = '0;
         if (dly < 0 && fbeat > s.trig_beat) dly = s.trig_dly;
         if (dly == 0 && sent < s.n_res) begin
            if (gap) gap = 0;
            else begin
               conv_out_valid = 1'b1;
               conv_out       = res_val(sent);
               sent++;
               if (gaps_left > 0) begin
                  gaps_left--;
                  gap = 1;
               end
            end
         end else if (dly > 0) dly--;
         if (done_cnt > d0 && sent >= s.n_res) break;
      end
      @(negedge clk);
      conv_out_valid = 1'b0;
      repeat (2) @(negedge clk);
      check({s.name, "_done_pulses"}, done_cnt - d0, 1);
      check({s.name, "_beats"}, fbeat, 196);
      check({s.name, "_gaps"}, gap_cnt - g0, 0);
      check({s.name, "_feed_data"}, feed_bad - f0, 0);
      check({s.name, "_first_beat_lat"}, first_beat_tick - rise_tick, 1);
      check({s.name, "_writes"}, wr_total - w0, s.exp_wr);
      check({s.name, "_ofm_data"}, ofm_bad - o0, 0);
      check({s.name, "_err"}, err, s.exp_err);
      check_range({s.name, "_done_lag"}, done_tick - last_wr_tick, s.lag_min, s.lag_max);
      check({s.name, "_busy_after"}, busy, 0);
   endtask

   initial begin
      int d0, r0, w0;
      tbl[0] = '{"nominal",     144, 195, 2, 0,  144, 0, 0,       2};
      tbl[1] = '{"interleaved", 144, 30,  0, 26, 144, 0, 0,       2};
      tbl[2] = '{"timeout",     100, 195, 2, 0,  100, 1, TIMEOUT, TIMEOUT};
      tbl[3] = '{"extra",       145, 195, 2, 0,  144, 1, 0,       2};

      rst_n = 1'b0; start = 1'b0; conv_out_valid = 1'b0; conv_out = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, err, ifm_rd_en, ifm_rd_addr, wgt_rd_en, wgt_rd_addr,
            conv_in_valid, conv_ifm, conv_weight, ofm_wr_en, ofm_wr_addr, ofm_wr_data}, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 4; i++) run_frame(tbl[i]);

      // Spurious result while idle, then a clean frame must clear err
      run_frame(tbl[0]);
      w0 = wr_total;
      @(negedge clk) conv_out_valid = 1'b1; conv_out = res_val(7);
      @(negedge clk) conv_out_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_spurious_err", err, 1);
      check("idle_spurious_nowrite", wr_total - w0, 0);
      run_frame(tbl[0]);

      // Start held for 300 cycles: one frame per IDLE visit, start in DONE ignored
      d0 = done_cnt; r0 = rise_cnt;
      @(negedge clk) start = 1'b1;
      for (int c = 0; c < 900; c++) begin
         @(negedge clk);
         if (c == 300) start = 1'b0;
         if (done_cnt >= d0 + 2 && c > 300) break;
      end
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("held_done_pulses", done_cnt - d0, 2);
      check("held_frames", rise_cnt - r0, 2);
      check("held_restart_gap", rise_gap, 2);

      // Async reset in the middle of FEED
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < 400 && fbeat < 100; c++) @(negedge clk);
      check("reset_reached_beat100", fbeat >= 100, 1);
      #2 rst_n = 1'b0;
      #1 check("midframe_reset_outputs", {busy, done, err, ifm_rd_en, ifm_rd_addr, wgt_rd_en,
            wgt_rd_addr, conv_in_valid, conv_ifm, conv_weight, ofm_wr_en, ofm_wr_addr,
            ofm_wr_data}, 0);
      repeat (2) @(negedge clk);
      check("midframe_reset_idle", {busy, ifm_rd_en, conv_in_valid}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(tbl[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
